// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST front-end: frame geometry, address width and
// the pixel-loader state encoding.
package mnist_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int IMG_PIX = IMG_W * IMG_H;
    localparam int BYTES   = IMG_PIX / 8;
    localparam int ADDR_W  = 7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

    // True when a byte address falls inside the frame buffer.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr <= LAST_ADDR);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchroniser for host pins that are asynchronous to clk.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mnist_pixel_loader.sv
// Receives one packed binary 28x28 frame over a 4-phase REQ/ACK host handshake and
// holds it in a flop buffer for the classifier core until released.
module mnist_pixel_loader
    import mnist_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        host_data,
    input  logic              host_req,
    input  logic              host_sof,
    output logic              host_ack,
    output logic              frame_valid,
    input  logic              frame_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_sof,
    output logic              err_busy
);

    logic              req_sync_s;
    logic              req_prev_q;
    logic              req_rise_s;
    logic              accept_s;
    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_sof_q, err_sof_d;
    logic              err_busy_q, err_busy_d;
    logic              ack_q, ack_d;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [7:0]        buf_q [BYTES];

    sync_ff #(.STAGES(SYNC_STG)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (host_req),
        .q_o   (req_sync_s)
    );

    assign req_rise_s = req_sync_s & ~req_prev_q;
    // A rising REQ is only honoured once the previous handshake has fully closed.
    assign accept_s   = req_rise_s & ~ack_q;

    // Control registers: edge detector, FSM state, counters, flags, acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q    <= 1'b0;
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            err_sof_q     <= 1'b0;
            err_busy_q    <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            req_prev_q    <= req_sync_s;
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_valid_q <= frame_valid_d;
            err_sof_q     <= err_sof_d;
            err_busy_q    <= err_busy_d;
            ack_q         <= ack_d;
        end
    end

    // Next-state, buffer write strobe and acknowledge generation.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        frame_valid_d = frame_valid_q;
        err_sof_d     = err_sof_q;
        err_busy_d    = err_busy_q;
        wr_en_s       = 1'b0;
        wr_addr_s     = '0;
        // Ack stays up until the synchronised request drops, for every request.
        ack_d         = ack_q ? req_sync_s : req_rise_s;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (host_sof) begin
                        wr_en_s    = 1'b1;
                        wr_addr_s  = '0;
                        byte_cnt_d = 7'd1;
                        state_d    = LOAD;
                    end else begin
                        err_sof_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (host_sof) begin
                        err_sof_d  = 1'b1;
                        wr_addr_s  = '0;
                        byte_cnt_d = 7'd1;
                    end else begin
                        wr_addr_s  = byte_cnt_q;
                        byte_cnt_d = byte_cnt_q + 7'd1;
                        if (byte_cnt_q == LAST_ADDR) begin
                            state_d       = FULL;
                            frame_valid_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            FULL: begin
                // Bytes arriving while full are dropped; release still takes effect.
                if (accept_s) begin
                    err_busy_d = 1'b1;
                end else begin
                    err_busy_d = err_busy_q;
                end
                if (frame_release) begin
                    frame_valid_d = 1'b0;
                    byte_cnt_d    = '0;
                    state_d       = IDLE;
                end else begin
                    frame_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                frame_valid_d = 1'b0;
                byte_cnt_d    = '0;
            end
        endcase
    end

    // Frame buffer write port; contents are meaningless outside FULL, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[wr_addr_s] <= host_data;
        end
    end

    // Core read port with out-of-range addresses returning zero.
    always_comb begin
        if (addr_in_range(rd_addr)) begin
            rd_data = buf_q[rd_addr];
        end else begin
            rd_data = 8'h00;
        end
    end

    assign host_ack    = ack_q;
    assign frame_valid = frame_valid_q;
    assign err_sof     = err_sof_q;
    assign err_busy    = err_busy_q;

endmodule

// File: tb/tb_mnist_pixel_loader.sv
// Scoreboard bench for mnist_pixel_loader: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT.
module tb_mnist_pixel_loader;

    localparam int NB = 98;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_data;
    logic       host_req;
    logic       host_sof;
    logic       host_ack;
    logic       frame_valid;
    logic       frame_release;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_sof;
    logic       err_busy;

    typedef enum {K_RD, K_FV, K_ACK, K_ESOF, K_EBUSY, K_VAL} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] exp;
        logic [7:0] act;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] model [NB];
    int         rl, fl;

    mnist_pixel_loader #(.SYNC_STG(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_data     (host_data),
        .host_req      (host_req),
        .host_sof      (host_sof),
        .host_ack      (host_ack),
        .frame_valid   (frame_valid),
        .frame_release (frame_release),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .err_sof       (err_sof),
        .err_busy      (err_busy)
    );

    always #5 clk = ~clk;

    // Monitor: compares the oldest queued expectation against the DUT.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] got;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_RD:    got = rd_data;
                K_FV:    got = {7'd0, frame_valid};
                K_ACK:   got = {7'd0, host_ack};
                K_ESOF:  got = {7'd0, err_sof};
                K_EBUSY: got = {7'd0, err_busy};
                K_VAL:   got = e.act;
                default: got = 8'hxx;
            endcase
            n_chk++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.exp);
            end
        end
    end

    task automatic chk(input kind_t k, input logic [7:0] exp, input string nm,
                       input logic [7:0] act);
        exp_t e;
        e.kind = k;
        e.exp  = exp;
        e.act  = act;
        e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input int hi,
                             input int lo, output int rise_lat, output int fall_lat);
        int lat;
        @(posedge clk);
        #1;
        host_data = d;
        host_sof  = sof;
        host_req  = 1'b1;
        lat = 0;
        while (!host_ack && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rise_lat = lat;
        if (!host_ack) chk(K_VAL, 8'd1, "ack_rise_timeout", 8'd0);
        repeat (hi) begin
            @(posedge clk);
            #1;
        end
        host_req = 1'b0;
        lat = 0;
        while (host_ack && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        fall_lat = lat;
        if (host_ack) chk(K_VAL, 8'd1, "ack_fall_timeout", 8'd0);
        host_sof = 1'b0;
        repeat (lo) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string nm);
        for (int i = 0; i < NB; i++) begin
            rd_addr = 7'(i);
            chk(K_RD, model[i], nm, 8'd0);
        end
    endtask

    task automatic pulse_release();
        @(posedge clk);
        #1;
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        frame_release = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        host_data     = 8'h00;
        host_req      = 1'b0;
        host_sof      = 1'b0;
        frame_release = 1'b0;
        rd_addr       = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({host_ack, frame_valid, err_sof, err_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_direct: got %b, expected 0000",
                     {host_ack, frame_valid, err_sof, err_busy});
        end
        chk(K_ACK,   8'd0, "rst_ack",   8'd0);
        chk(K_FV,    8'd0, "rst_fv",    8'd0);
        chk(K_ESOF,  8'd0, "rst_esof",  8'd0);
        chk(K_EBUSY, 8'd0, "rst_ebusy", 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full frame with handshake timing on the first byte (req held 20 clk).
        for (int i = 0; i < NB; i++) model[i] = 8'(i);
        send_byte(8'h00, 1'b1, 20, 2, rl, fl);
        n_chk++;
        if (rl != 3) begin
            n_fail++;
            $display("FAIL ack_rise_direct: got %0d, expected 3", rl);
        end
        n_chk++;
        if (fl != 3) begin
            n_fail++;
            $display("FAIL ack_fall_direct: got %0d, expected 3", fl);
        end
        chk(K_VAL, 8'd3, "ack_rise_latency", 8'(rl));
        chk(K_VAL, 8'd3, "ack_fall_latency", 8'(fl));
        for (int i = 1; i < NB - 1; i++) send_byte(model[i], 1'b0, 0, 1, rl, fl);
        chk(K_FV, 8'd0, "fv_before_last_byte", 8'd0);
        send_byte(model[NB-1], 1'b0, 0, 1, rl, fl);
        n_chk++;
        if (frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fv_direct: got %b, expected 1", frame_valid);
        end
        chk(K_FV, 8'd1, "fv_after_last_byte", 8'd0);
        check_frame("rd_frame0");
        rd_addr = 7'd100;
        chk(K_RD,    8'h00, "rd_out_of_range", 8'd0);
        chk(K_ESOF,  8'd0,  "frame0_esof",     8'd0);
        chk(K_EBUSY, 8'd0,  "frame0_ebusy",    8'd0);

        // Byte while full is dropped and flagged; release then clean reload.
        send_byte(8'hFF, 1'b0, 0, 1, rl, fl);
        n_chk++;
        if (err_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_direct: got %b, expected 1", err_busy);
        end
        chk(K_EBUSY, 8'd1, "busy_flag", 8'd0);
        rd_addr = 7'd0;
        chk(K_RD, 8'h00, "busy_no_overwrite", 8'd0);
        chk(K_FV, 8'd1,  "busy_fv_held",      8'd0);
        pulse_release();
        n_chk++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_direct: got %b, expected 0", frame_valid);
        end
        chk(K_FV, 8'd0, "fv_after_release", 8'd0);
        for (int i = 0; i < NB; i++) model[i] = 8'hC0 ^ 8'(i);
        for (int i = 0; i < NB; i++) send_byte(model[i], (i == 0), 0, 1, rl, fl);
        chk(K_FV,   8'd1, "reload_fv",   8'd0);
        chk(K_ESOF, 8'd0, "reload_esof", 8'd0);
        check_frame("rd_reload");
        pulse_release();

        // Reset asserted in the middle of a handshake.
        @(posedge clk);
        #1;
        host_data = 8'h11;
        host_sof  = 1'b1;
        host_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(K_ACK, 8'd1, "ack_before_reset", 8'd0);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({host_ack, frame_valid, err_sof, err_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_direct: got %b, expected 0000",
                     {host_ack, frame_valid, err_sof, err_busy});
        end
        chk(K_ACK,   8'd0, "midrst_ack",   8'd0);
        chk(K_FV,    8'd0, "midrst_fv",    8'd0);
        chk(K_ESOF,  8'd0, "midrst_esof",  8'd0);
        chk(K_EBUSY, 8'd0, "midrst_ebusy", 8'd0);
        host_req = 1'b0;
        host_sof = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Missing SOF, then SOF in the middle of a frame forcing a restart.
        send_byte(8'hAA, 1'b0, 0, 1, rl, fl);
        chk(K_ESOF, 8'd1, "esof_missing_sof", 8'd0);
        chk(K_FV,   8'd0, "fv_after_missing_sof", 8'd0);
        for (int i = 0; i < 50; i++) send_byte(8'hFF - 8'(i), (i == 0), 0, 1, rl, fl);
        model[0] = 8'h5A;
        for (int i = 1; i < NB; i++) model[i] = 8'(i * 3);
        send_byte(model[0], 1'b1, 0, 1, rl, fl);
        for (int i = 1; i < NB - 1; i++) send_byte(model[i], 1'b0, 0, 1, rl, fl);
        chk(K_FV, 8'd0, "fv_restart_97_bytes", 8'd0);
        send_byte(model[NB-1], 1'b0, 0, 1, rl, fl);
        chk(K_FV,    8'd1, "fv_restart_98_bytes", 8'd0);
        chk(K_EBUSY, 8'd0, "restart_ebusy",       8'd0);
        check_frame("rd_restart");
        pulse_release();

        // Three frames with random data and jittered handshake phases.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NB; i++) model[i] = 8'($urandom);
            for (int i = 0; i < NB; i++)
                send_byte(model[i], (i == 0), $urandom_range(0, 6), $urandom_range(1, 7), rl, fl);
            chk(K_FV,    8'd1, "jitter_fv",    8'd0);
            check_frame("rd_jitter");
            chk(K_ESOF,  8'd0, "jitter_esof",  8'd0);
            chk(K_EBUSY, 8'd0, "jitter_ebusy", 8'd0);
            pulse_release();
            chk(K_FV,    8'd0, "jitter_release", 8'd0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
